// File: rtl/alu_resp_pkg.sv
// Shared constants for the ALU response block: word width, opcodes, FSM states.
package alu_resp_pkg;
  localparam int WORD_W = 16;
  localparam int OP_W   = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 5'h00,
    OP_SUB = 5'h01,
    OP_AND = 5'h02,
    OP_OR  = 5'h03,
    OP_XOR = 5'h04,
    OP_NOT = 5'h05,
    OP_SHL = 5'h06,
    OP_SHR = 5'h07,
    OP_SLT = 5'h08,
    OP_MUL = 5'h09
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Opcodes above MUL are reserved and produce an error response.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_W'(OP_MUL);
  endfunction
endpackage

// File: rtl/alu_resp_if.sv
// Request/response handshake bundle between an initiator and alu_resp.
interface alu_resp_if #(
  parameter int WIDTH = alu_resp_pkg::WORD_W,
  parameter int OPW   = alu_resp_pkg::OP_W
);
  logic             req_valid;
  logic             req_ready;
  logic [OPW-1:0]   req_op;
  logic [WIDTH-1:0] req_x;
  logic [WIDTH-1:0] req_y;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_z;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_err
  );
  modport slave (
    input  req_valid, req_op, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_err
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low WIDTH bits kept.
module alu_mul_iter #(
  parameter int WIDTH = alu_resp_pkg::WORD_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CW-1:0]    cnt;

  // Load on start, then WIDTH iterations; done holds for one cycle before busy drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
      busy   <= 1'b1;
    end else if (busy && cnt != '0) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end else if (busy) begin
      busy   <= 1'b0;
    end
  end

  assign done = busy && (cnt == '0);
  assign p    = acc;
endmodule

// File: rtl/alu_resp.sv
// Single-outstanding ALU: accept in IDLE, execute (1 cycle or iterative MUL), hold result until consumed.
module alu_resp
  import alu_resp_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int OPW   = OP_W
) (
  input  logic        clk,
  input  logic        reset_n,
  alu_resp_if.slave   bus,
  output logic [15:0] op_count
);
  state_e           state_q, state_d;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] x_q, y_q, z_q, alu_z, mul_p;
  logic             err_q, alu_err, accept, mul_start, mul_busy, mul_done;

  assign accept    = bus.req_valid && (state_q == S_IDLE);
  assign mul_start = accept && (bus.req_op == OPW'(OP_MUL));

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_z     = z_q;
  assign bus.rsp_err   = err_q;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (mul_start),
    .a      (bus.req_x),
    .b      (bus.req_y),
    .busy   (mul_busy),
    .done   (mul_done),
    .p      (mul_p)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: MUL goes to the iterative unit, everything else (including illegal) takes one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = mul_start ? S_MUL : S_EXEC;
      S_EXEC: state_d = S_DONE;
      S_MUL:  if (mul_done) state_d = S_DONE;
      S_DONE: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture operands at accept so later req_* activity cannot disturb the in-flight op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q <= '0;
      x_q  <= '0;
      y_q  <= '0;
    end else if (accept) begin
      op_q <= bus.req_op;
      x_q  <= bus.req_x;
      y_q  <= bus.req_y;
    end
  end

  // Single-cycle ops; all arithmetic wraps at WIDTH bits.
  always_comb begin
    alu_z   = '0;
    alu_err = !op_legal(OP_W'(op_q));
    case (op_q)
      OPW'(OP_ADD): alu_z = x_q + y_q;
      OPW'(OP_SUB): alu_z = x_q - y_q;
      OPW'(OP_AND): alu_z = x_q & y_q;
      OPW'(OP_OR):  alu_z = x_q | y_q;
      OPW'(OP_XOR): alu_z = x_q ^ y_q;
      OPW'(OP_NOT): alu_z = ~x_q;
      OPW'(OP_SHL): alu_z = x_q << y_q[3:0];
      OPW'(OP_SHR): alu_z = x_q >> y_q[3:0];
      OPW'(OP_SLT): alu_z = WIDTH'($signed(x_q) < $signed(y_q));
      default:      alu_z = '0;
    endcase
  end

  // Result register: loaded on entry to DONE, held until consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z_q   <= '0;
      err_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      z_q   <= alu_z;
      err_q <= alu_err;
    end else if (state_q == S_MUL && mul_done) begin
      z_q   <= mul_p;
      err_q <= 1'b0;
    end
  end

  // Completed-response counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  op_count <= '0;
    else if (state_q == S_DONE && bus.rsp_ready)   op_count <= op_count + 16'd1;
  end

  // Busy flag of the multiplier is implied by the MUL state; keep it observable for lint.
  logic mul_unused;
  assign mul_unused = mul_busy;
endmodule

// File: tb/tb_alu_resp.sv
// Directed bench for alu_resp: hand-computed vectors, latency, hold/backpressure and reset abort.
module tb_alu_resp;
  import alu_resp_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] op_count;
  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt = 16'd0;

  alu_resp_if #(.WIDTH(16), .OPW(5)) bus ();

  alu_resp #(.WIDTH(16), .OPW(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, verify latency, result and consume; operands are scrambled right after accept.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [15:0] x,
                        input logic [15:0] y, input int lat, input logic [15:0] z, input logic err);
    int n;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_x = x; bus.req_y = y;
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_x = ~x; bus.req_y = ~y; bus.req_op = 5'h00;
    chk({tag, "_busy"}, 32'({bus.req_ready, bus.rsp_valid}), 32'd0);
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_z"}, 32'(bus.rsp_z), 32'(z));
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'(err));
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    exp_cnt++;
    chk({tag, "_cnt"}, 32'(op_count), 32'(exp_cnt));
    chk({tag, "_idle"}, 32'({bus.req_ready, bus.rsp_valid}), 32'b10);
  endtask

  initial begin
    logic [15:0] held;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_x = '0; bus.req_y = '0; bus.rsp_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_z",     32'(bus.rsp_z),     32'd0);
    chk("rst_err",   32'(bus.rsp_err),   32'd0);
    chk("rst_cnt",   32'(op_count),      32'd0);
    @(posedge clk); #1; reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);

    run_op("add",   5'h00, 16'h0003, 16'h0004, 1,  16'h0007, 1'b0);
    run_op("sub",   5'h01, 16'h0000, 16'h0001, 1,  16'hFFFF, 1'b0);
    run_op("slt",   5'h08, 16'hFFFF, 16'h0001, 1,  16'h0001, 1'b0);
    run_op("slt0",  5'h08, 16'h0001, 16'hFFFF, 1,  16'h0000, 1'b0);
    run_op("shr",   5'h07, 16'h8000, 16'h000F, 1,  16'h0001, 1'b0);
    run_op("shl",   5'h06, 16'h0001, 16'h0014, 1,  16'h0010, 1'b0);
    run_op("and",   5'h02, 16'hF0F0, 16'h3C3C, 1,  16'h3030, 1'b0);
    run_op("or",    5'h03, 16'hF0F0, 16'h3C3C, 1,  16'hFCFC, 1'b0);
    run_op("xor",   5'h04, 16'hF0F0, 16'h3C3C, 1,  16'hCCCC, 1'b0);
    run_op("not",   5'h05, 16'h00FF, 16'h1234, 1,  16'hFF00, 1'b0);
    run_op("addw",  5'h00, 16'hFFFF, 16'h0002, 1,  16'h0001, 1'b0);
    run_op("mul",   5'h09, 16'h0012, 16'h0034, 17, 16'h03A8, 1'b0);
    run_op("mulff", 5'h09, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 1'b0);
    run_op("ill1f", 5'h1F, 16'h1234, 16'h5678, 1,  16'h0000, 1'b1);
    run_op("ill0a", 5'h0A, 16'h0001, 16'h0001, 1,  16'h0000, 1'b1);
    run_op("addok", 5'h00, 16'h0001, 16'h0001, 1,  16'h0002, 1'b0);

    // Backpressure: hold DONE for 5 cycles while hammering the request side.
    bus.req_valid = 1'b1; bus.req_op = 5'h00; bus.req_x = 16'h0005; bus.req_y = 16'h0006;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
    held = bus.rsp_z;
    chk("hold_z0", 32'(held), 32'h000B);
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1; bus.req_op = 5'(i); bus.req_x = 16'(i * 16'h1111); bus.req_y = 16'(~i);
      @(posedge clk); #1;
      chk("hold_z",     32'(bus.rsp_z),     32'(held));
      chk("hold_rdy",   32'(bus.req_ready), 32'd0);
      chk("hold_vld",   32'(bus.rsp_valid), 32'd1);
    end
    bus.req_valid = 1'b0;
    chk("hold_cnt", 32'(op_count), 32'(exp_cnt));
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    exp_cnt++;
    chk("hold_rel_cnt",  32'(op_count),      32'(exp_cnt));
    chk("hold_rel_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    chk("hold_no_acc", 32'(bus.req_ready), 32'd1);

    // Reset abort at cycle 8 of a MUL.
    bus.req_valid = 1'b1; bus.req_op = 5'h09; bus.req_x = 16'h0012; bus.req_y = 16'h0034;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    reset_n = 1'b0; exp_cnt = 16'd0;
    #1;
    chk("abort_vld", 32'(bus.rsp_valid), 32'd0);
    chk("abort_cnt", 32'(op_count),      32'd0);
    chk("abort_rdy", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1; reset_n = 1'b1;
    @(posedge clk); #1;
    run_op("post", 5'h00, 16'h0003, 16'h0004, 1, 16'h0007, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/alu_resp.md
ALU_RESP -- requirements
Module: alu_resp

Interface
- REQ-001: Parameter WIDTH, default 16, datapath width; equals the codebase `WORD width.
- REQ-002: Parameter OPW, default 5, opcode width.
- REQ-003: clk  input  1  single clock; all state changes on rising edge.
- REQ-004: reset_n  input  1  asynchronous, active-low reset.
- REQ-005: req_valid  input  1  initiator presents an operation.
- REQ-006: req_ready  output  1  block can accept an operation this cycle.
- REQ-007: req_op  input  OPW  ALU opcode.
- REQ-008: req_x  input  WIDTH  operand X.
- REQ-009: req_y  input  WIDTH  operand Y.
- REQ-010: rsp_valid  output  1  result available.
- REQ-011: rsp_ready  input  1  initiator consumes the result this cycle.
- REQ-012: rsp_z  output  WIDTH  result.
- REQ-013: rsp_err  output  1  result came from an illegal opcode.
- REQ-014: op_count  output  16  number of completed responses, wraps 0xFFFF->0x0000.

Function
- REQ-015: Request accepted on a rising edge where req_valid && req_ready; req_op/req_x/req_y are captured into internal registers at that edge.
- REQ-016: States IDLE, EXEC, MUL, DONE; req_ready = 1 only in IDLE; rsp_valid = 1 only in DONE.
- REQ-017: IDLE -> MUL on accept with op 0x09; IDLE -> EXEC on accept with any other op; otherwise IDLE holds.
- REQ-018: EXEC -> DONE after exactly one cycle; result accepted at edge N is visible with rsp_valid after edge N+1.
- REQ-019: MUL runs 16 shift-add iterations, one per cycle; MUL -> DONE after edge N+17 of an accept at edge N.
- REQ-020: DONE -> IDLE on a rising edge with rsp_ready = 1; op_count increments on that edge; rsp_z/rsp_err held stable while rsp_ready = 0.
- REQ-021: Opcodes: 0x00 ADD X+Y; 0x01 SUB X-Y; 0x02 AND; 0x03 OR; 0x04 XOR; 0x05 NOT X; 0x06 SHL X<<Y[3:0]; 0x07 SHR logical X>>Y[3:0]; 0x08 SLT signed (X<Y) ? 1 : 0; 0x09 MUL low WIDTH bits of X*Y.
- REQ-022: All arithmetic is modulo 2^WIDTH; carries and overflow are discarded, with no flag.
- REQ-023: Any other opcode (0x0A-0x1F): rsp_z = 0, rsp_err = 1, latency as EXEC; legal ops give rsp_err = 0.
- REQ-024: req_valid while not in IDLE is ignored; no queueing, one operation outstanding.
- REQ-025: Changes on req_* after acceptance do not affect the in-flight result.
- REQ-026: Back-to-back: the earliest next acceptance is the cycle after DONE exits, i.e. a minimum of 3 cycles per single-cycle op.

Reset
- REQ-027: reset_n low asynchronously forces IDLE, req_ready = 1 (after release), rsp_valid = 0, rsp_z = 0, rsp_err = 0, op_count = 0.
- REQ-028: Reset during MUL, EXEC or DONE aborts the operation; no response is produced and op_count is not incremented.

Structure
- REQ-029: Opcode constants, the state encoding and the WORD width belong in a shared package/include used by alu, alu_resp and the benches.
- REQ-030: The iterative multiplier is one sub-module, alu_mul_iter (start/busy/done, WIDTH-bit low-product output); all other ops are combinational in alu_resp.

Verification
- REQ-031: ADD 0x0003,0x0004 accepted at edge 0 -> rsp_valid after edge 1, rsp_z = 0x0007, rsp_err = 0, op_count 0->1 on consume.
- REQ-032: SUB 0x0000,0x0001 -> 0xFFFF; SLT 0xFFFF,0x0001 -> 0x0001; SHR 0x8000,0x000F -> 0x0001.
- REQ-033: MUL 0x0012,0x0034 at edge 0 -> rsp_valid after edge 17, rsp_z = 0x03A8; MUL 0xFFFF,0xFFFF -> 0x0001.
- REQ-034: Op 0x1F -> rsp_z = 0x0000, rsp_err = 1; then ADD -> rsp_err = 0.
- REQ-035: Hold rsp_ready = 0 for 5 cycles in DONE while toggling req_* -> rsp_z stable, req_ready = 0, no new accept; release -> IDLE, op_count +1.
- REQ-036: Assert reset_n low at cycle 8 of a MUL -> rsp_valid = 0, op_count = 0, IDLE immediately; the next ADD completes normally.
